mat_result_serializer: RTL and testbench

Output stage directly downstream of the SIMD matrix multiplier. Captures each N×N signed result matrix on the multiplier's `valid_out` pulse into a two-slot ping-pong buffer, narrows every element to the stream width, and drains the matrix row-major as LANES elements per beat over a valid/ready stream. Absorbs one matrix of backpressure, since the multiplier itself cannot stall. Flags a dropped matrix with a sticky overflow.

---
 rtl/mat_simd_pkg.sv | 23 ++
 rtl/mat_ser_narrow.sv | 39 +++
 rtl/mat_result_serializer.sv | 132 +++++++++++++
 tb/tb_mat_result_serializer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_simd_pkg.sv
// Shared constants, element types and helpers for the SIMD matrix datapath.
// Used by the result serializer and its lane narrower.
package mat_simd_pkg;

    localparam int DEF_N        = 2;
    localparam int DEF_W_OUT    = 32;
    localparam int DEF_W_STREAM = 16;
    localparam int DEF_LANES    = 4;

    typedef logic signed [DEF_W_OUT-1:0]    elem_t;
    typedef logic signed [DEF_W_STREAM-1:0] stream_elem_t;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

    // Number of output beats needed to carry one N x N matrix.
    function automatic int beats_f(input int n, input int lanes);
        return (n * n + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/mat_ser_narrow.sv
// Single-element signed narrower, W_IN -> W_NAR bits.
// Saturates when MAT_SER_SAT_EN is defined, otherwise wraps (truncates).
module mat_ser_narrow
    import mat_simd_pkg::*;
#(
    parameter int W_IN  = DEF_W_OUT,
    parameter int W_NAR = DEF_W_STREAM
) (
    input  logic [W_IN-1:0]  i_elem,
    output logic [W_NAR-1:0] o_elem
);

`ifdef MAT_SER_SAT_EN
    logic w_fits;

    // Value fits when every bit above the target sign bit copies the sign.
    assign w_fits = (i_elem[W_IN-1:W_NAR-1]
                     == {(W_IN-W_NAR+1){i_elem[W_IN-1]}});

    // Clamp out-of-range values to the nearest representable extreme.
    always_comb begin
        if (w_fits) begin
            o_elem = i_elem[W_NAR-1:0];
        end else if (i_elem[W_IN-1]) begin
            o_elem = {1'b1, {(W_NAR-1){1'b0}}};
        end else begin
            o_elem = {1'b0, {(W_NAR-1){1'b1}}};
        end
    end
`else
    assign o_elem = i_elem[W_NAR-1:0];

    if (W_IN > W_NAR) begin : g_drop
        logic w_unused_hi;
        assign w_unused_hi = ^i_elem[W_IN-1:W_NAR];
    end
`endif

endmodule

// File: rtl/mat_result_serializer.sv
// Ping-pong buffer that captures N x N result matrices and streams them
// row-major, LANES elements per beat. Narrowing mode: MAT_SER_SAT_EN.
module mat_result_serializer
    import mat_simd_pkg::*;
#(
    parameter int W_OUT    = DEF_W_OUT,
    parameter int N        = DEF_N,
    parameter int LANES    = DEF_LANES,
    parameter int W_STREAM = DEF_W_STREAM
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cen,
    input  logic                                valid_in,
    input  logic [N-1:0][N-1:0][W_OUT-1:0]      result,
    output logic                                in_ready,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LANES-1:0][W_STREAM-1:0]      out_data,
    output logic                                out_last,
    output logic                                overflow
);

    localparam int BEATS = beats_f(N, LANES);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ELEMS = N * N;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef logic [BEATS-1:0][LANES-1:0][W_OUT-1:0] mat_t;

    mat_t            r_buf [2];
    rd_state_t       r_state;
    rd_state_t       w_state_nxt;
    logic [1:0]      r_count;
    logic [1:0]      w_count_nxt;
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [BW-1:0]   r_beat;
    logic [BW-1:0]   w_beat_nxt;
    logic            r_overflow;
    logic            w_cap;
    logic            w_xfer;
    logic            w_pop;
    logic            w_accept;
    wire  mat_t      w_cap_mat;
    logic [LANES-1:0][W_OUT-1:0] w_beat_elems;

    // Lay the matrix out beat-major; padding lanes are stored as zero.
    for (genvar k = 0; k < BEATS * LANES; k++) begin : g_cap
        if (k < ELEMS) begin : g_elem
            assign w_cap_mat[k/LANES][k%LANES] = result[k/N][k%N];
        end else begin : g_pad
            assign w_cap_mat[k/LANES][k%LANES] = '0;
        end
    end

    assign w_cap     = cen & valid_in;
    assign out_valid = (r_state == RD_STREAM);
    assign out_last  = out_valid & (r_beat == LAST_BEAT);
    assign w_xfer    = cen & out_valid & out_ready;
    assign w_pop     = w_xfer & (r_beat == LAST_BEAT);
    // A full buffer still takes a matrix when the oldest slot frees now.
    assign w_accept  = w_cap & ((r_count != 2'd2) | w_pop);
    assign in_ready  = (r_count != 2'd2);
    assign overflow  = r_overflow;

    // Next occupancy, read state and beat index.
    always_comb begin
        w_count_nxt = r_count;
        w_beat_nxt  = r_beat;
        unique case ({w_accept, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
        if (w_pop) begin
            w_beat_nxt = '0;
        end else if (w_xfer) begin
            w_beat_nxt = r_beat + BW'(1);
        end
        w_state_nxt = (w_count_nxt == 2'd0) ? RD_IDLE : RD_STREAM;
    end

    // Control state: pointers, occupancy, beat and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RD_IDLE;
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_beat     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_beat  <= w_beat_nxt;
            if (w_accept) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_cap && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Matrix storage; contents are don't-care until occupancy says valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_ptr] <= w_cap_mat;
        end
    end

    assign w_beat_elems = r_buf[r_rd_ptr][r_beat];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [W_STREAM-1:0] w_nar;

        mat_ser_narrow #(
            .W_IN  (W_OUT),
            .W_NAR (W_STREAM)
        ) u_narrow (
            .i_elem (w_beat_elems[l]),
            .o_elem (w_nar)
        );

        assign out_data[l] = out_valid ? w_nar : '0;
    end

endmodule

// File: tb/tb_mat_result_serializer.sv
// Directed bench for mat_result_serializer, N=2 LANES=2 W_STREAM=16.
// Expected narrowing values follow MAT_SER_SAT_EN.
module tb_mat_result_serializer;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cen;
    logic                   valid_in;
    logic [1:0][1:0][31:0]  result;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [1:0][15:0]       out_data;
    logic                   out_last;
    logic                   overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mat_result_serializer #(
        .W_OUT    (32),
        .N        (2),
        .LANES    (2),
        .W_STREAM (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .valid_in  (valid_in),
        .result    (result),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mat(input int a, input int b, input int c, input int d);
        result[0][0] = 32'(a);
        result[0][1] = 32'(b);
        result[1][0] = 32'(c);
        result[1][1] = 32'(d);
    endtask

    task automatic cap(input int a, input int b, input int c, input int d);
        set_mat(a, b, c, d);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cen = 1'b1;
        valid_in = 1'b0;
        out_ready = 1'b0;
        set_mat(0, 0, 0, 0);
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({out_valid, out_last, out_data, in_ready, overflow}
                !== {1'b0, 1'b0, 32'd0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle c%0d: got v%b l%b d%h ir%b ov%b, exp v0 l0 d0 ir1 ov0",
                         i, out_valid, out_last, out_data, in_ready, overflow);
            end
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        cap(1, 2, 3, 4);
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 16'd2, 16'd1}) begin
            errors++;
            $display("FAIL single_b0: got v%b l%b d%h, exp v1 l0 d00020001",
                     out_valid, out_last, out_data);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 16'd4, 16'd3}) begin
            errors++;
            $display("FAIL single_b1: got v%b l%b d%h, exp v1 l1 d00040003",
                     out_valid, out_last, out_data);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data} !== 34'd0) begin
            errors++;
            $display("FAIL single_idle: got v%b l%b d%h, exp all 0",
                     out_valid, out_last, out_data);
        end
    endtask

    task automatic test_narrow();
        logic [15:0] e0;
        logic [15:0] e1;
`ifdef MAT_SER_SAT_EN
        e0 = 16'h7FFF;
        e1 = 16'h8000;
`else
        e0 = 16'h9C40;
        e1 = 16'h63C0;
`endif
        out_ready = 1'b1;
        cap(40000, -40000, 5, -5);
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, e1, e0}) begin
            errors++;
            $display("FAIL narrow_b0: got v%b l%b d%h, exp v1 l0 d%h%h",
                     out_valid, out_last, out_data, e1, e0);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 16'hFFFB, 16'h0005}) begin
            errors++;
            $display("FAIL narrow_b1: got v%b l%b d%h, exp v1 l1 dfffb0005",
                     out_valid, out_last, out_data);
        end
        tick();
    endtask

    task automatic test_cen();
        out_ready = 1'b1;
        cen = 1'b0;
        set_mat(7, 7, 7, 7);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        cen = 1'b1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL cen_nocap: got v%b ir%b, exp v0 ir1", out_valid, in_ready);
        end
        cap(61, 62, 63, 64);
        cen = 1'b0;
        repeat (2) tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 16'd62, 16'd61}) begin
            errors++;
            $display("FAIL cen_hold: got v%b l%b d%h, exp v1 l0 d003e003d",
                     out_valid, out_last, out_data);
        end
        cen = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 16'd64, 16'd63}) begin
            errors++;
            $display("FAIL cen_resume: got v%b l%b d%h, exp v1 l1 d0040003f",
                     out_valid, out_last, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cen_idle: got v%b, exp v0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int m;
        int b;
        int lo;
        out_ready = 1'b1;
        cap(101, 102, 103, 104);
        for (int c = 0; c < 6; c++) begin
            m  = c / 2;
            b  = c % 2;
            lo = 100 * (m + 1) + 1 + 2 * b;
            checks++;
            if ({out_valid, out_last, out_data, in_ready, overflow}
                !== {1'b1, 1'(b), 16'(lo + 1), 16'(lo), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL b2b c%0d: got v%b l%b d%h ir%b ov%b, exp v1 l%0d lanes %0d,%0d ir1 ov0",
                         c, out_valid, out_last, out_data, in_ready, overflow, b, lo, lo + 1);
            end
            if (b == 1 && m + 1 < 3) begin
                set_mat(100 * (m + 2) + 1, 100 * (m + 2) + 2,
                        100 * (m + 2) + 3, 100 * (m + 2) + 4);
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            tick();
        end
        valid_in = 1'b0;
        checks++;
        if ({out_valid, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end: got v%b ov%b, exp v0 ov0", out_valid, overflow);
        end
    endtask

    task automatic test_backpressure();
        int lo [4] = '{10, 12, 20, 22};
        out_ready = 1'b0;
        cap(10, 11, 12, 13);
        cap(20, 21, 22, 23);
        checks++;
        if ({out_valid, out_last, out_data, in_ready, overflow}
            !== {1'b1, 1'b0, 16'd11, 16'd10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bp_full: got v%b l%b d%h ir%b ov%b, exp v1 l0 d000b000a ir0 ov0",
                     out_valid, out_last, out_data, in_ready, overflow);
        end
        cap(30, 31, 32, 33);
        checks++;
        if ({overflow, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_ovf: got ov%b ir%b, exp ov1 ir0", overflow, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 16'd11, 16'd10}) begin
                errors++;
                $display("FAIL bp_stable c%0d: got v%b l%b d%h, exp v1 l0 d000b000a",
                         i, out_valid, out_last, out_data);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, out_last, out_data}
                !== {1'b1, 1'(i % 2), 16'(lo[i] + 1), 16'(lo[i])}) begin
                errors++;
                $display("FAIL bp_drain b%0d: got v%b l%b d%h, exp v1 l%0d lanes %0d,%0d",
                         i, out_valid, out_last, out_data, i % 2, lo[i], lo[i] + 1);
            end
            tick();
        end
        checks++;
        if ({out_valid, overflow} !== 2'b01) begin
            errors++;
            $display("FAIL bp_end: got v%b ov%b, exp v0 ov1", out_valid, overflow);
        end
    endtask

    task automatic test_cap_on_pop();
        int lo [3] = '{7, 9, 11};
        pulse_rst();
        tick();
        out_ready = 1'b0;
        cap(1, 2, 3, 4);
        cap(5, 6, 7, 8);
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_last, out_data, in_ready}
            !== {1'b1, 1'b1, 16'd4, 16'd3, 1'b0}) begin
            errors++;
            $display("FAIL cop_last: got v%b l%b d%h ir%b, exp v1 l1 d00040003 ir0",
                     out_valid, out_last, out_data, in_ready);
        end
        cap(9, 10, 11, 12);
        checks++;
        if ({out_valid, out_last, out_data, in_ready, overflow}
            !== {1'b1, 1'b0, 16'd6, 16'd5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL cop_cap: got v%b l%b d%h ir%b ov%b, exp v1 l0 d00060005 ir0 ov0",
                     out_valid, out_last, out_data, in_ready, overflow);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({out_valid, out_last, out_data}
                !== {1'b1, 1'((i + 1) % 2), 16'(lo[i] + 1), 16'(lo[i])}) begin
                errors++;
                $display("FAIL cop_drain b%0d: got v%b l%b d%h, exp v1 l%0d lanes %0d,%0d",
                         i, out_valid, out_last, out_data, (i + 1) % 2, lo[i], lo[i] + 1);
            end
        end
        tick();
        checks++;
        if ({out_valid, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL cop_end: got v%b ov%b, exp v0 ov0", out_valid, overflow);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        cap(1, 2, 3, 4);
        tick();
        checks++;
        if ({out_valid, out_last} !== 2'b11) begin
            errors++;
            $display("FAIL rmid_b1: got v%b l%b, exp v1 l1", out_valid, out_last);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, out_data, in_ready, overflow}
            !== {1'b0, 1'b0, 32'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rmid_async: got v%b l%b d%h ir%b ov%b, exp v0 l0 d0 ir1 ov0",
                     out_valid, out_last, out_data, in_ready, overflow);
        end
        #1;
        rst = 1'b0;
        tick();
        cap(50, 51, 52, 53);
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 16'd51, 16'd50}) begin
            errors++;
            $display("FAIL rmid_b0: got v%b l%b d%h, exp v1 l0 d00330032",
                     out_valid, out_last, out_data);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 16'd53, 16'd52}) begin
            errors++;
            $display("FAIL rmid_b1n: got v%b l%b d%h, exp v1 l1 d00350034",
                     out_valid, out_last, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_idle: got v%b, exp v0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_narrow();
        test_cen();
        test_back_to_back();
        test_backpressure();
        test_cap_on_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
